mem_bus_arbiter: RTL and testbench

Two-requester arbiter that shares one memory bus between the instruction-fetch port (port 0) and the load/store port (port 1). It sits between the CPU front ends and the bus width adapter or RAM, and uses the same per-port signal set on every side: addr, r_data, w_data, w_sel, re, we, ready, r_data_valid. A registered round-robin grant is held for the whole of one transaction, so the downstream bus only ever sees one requester's signals at a time.

---
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory bus between two requesters: port 0 (instruction fetch)
// and port 1 (load/store). A round-robin grant is registered and held for
// one whole transaction, so downstream only ever sees one requester.
//
// Ports
//   clk, rst                        clock, async active-high reset
//   addr_n, w_data_n, w_sel_n       requester n address / write data / byte enables
//   re_n, we_n                      requester n read / write request (held until done)
//   r_data_n                        read data to requester n (mirror of r_data_m)
//   ready_n, r_data_valid_n         write / read completion to requester n
//   addr_m, w_data_m, w_sel_m       downstream bus
//   re_m, we_m                      downstream strobes
//   r_data_m, ready_m, r_data_valid_m  downstream read data / completions
//   grant                           port currently owning the bus
//   busy                            high while a transaction is granted
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, downstream bus and all completions driven to 0
// BUSY  | port 'grant' owns the bus, its signals pass straight through

module mem_bus_arbiter #(
   parameter int AddrBusWidth = 32,
   parameter int BusWidth     = 32
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic [AddrBusWidth-1:0] addr_0,
   input  logic [BusWidth-1:0]     w_data_0,
   input  logic [BusWidth/8-1:0]   w_sel_0,
   input  logic                    re_0,
   input  logic                    we_0,
   output logic [BusWidth-1:0]     r_data_0,
   output logic                    ready_0,
   output logic                    r_data_valid_0,

   input  logic [AddrBusWidth-1:0] addr_1,
   input  logic [BusWidth-1:0]     w_data_1,
   input  logic [BusWidth/8-1:0]   w_sel_1,
   input  logic                    re_1,
   input  logic                    we_1,
   output logic [BusWidth-1:0]     r_data_1,
   output logic                    ready_1,
   output logic                    r_data_valid_1,

   output logic [AddrBusWidth-1:0] addr_m,
   output logic [BusWidth-1:0]     w_data_m,
   output logic [BusWidth/8-1:0]   w_sel_m,
   output logic                    re_m,
   output logic                    we_m,
   input  logic [BusWidth-1:0]     r_data_m,
   input  logic                    ready_m,
   input  logic                    r_data_valid_m,

   output logic                    grant,
   output logic                    busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state;
   logic   last;

   logic req_0, req_1;
   logic re_g, we_g, req_g, req_other;
   logic done;
   logic next_grant;

   assign req_0 = re_0 | we_0;
   assign req_1 = re_1 | we_1;

   assign re_g      = grant ? re_1 : re_0;
   assign we_g      = grant ? we_1 : we_0;
   assign req_g     = grant ? req_1 : req_0;
   assign req_other = grant ? req_0 : req_1;

   // A withdrawn request (abort) releases the bus exactly like a completion.
   assign done = (re_g & r_data_valid_m) | (we_g & ready_m) | ~req_g;

   // Tie goes to the port that was not granted most recently.
   assign next_grant = (req_0 & req_1) ? ~last : req_1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_0 | req_1) begin
                  state <= BUSY;
                  grant <= next_grant;
                  last  <= next_grant;
               end
            end
            BUSY: begin
               if (done) begin
                  // The finishing port's request at this edge is stale, so
                  // it is never re-granted directly; only handover or idle.
                  if (req_other) begin
                     grant <= ~grant;
                     last  <= ~grant;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy     = (state == BUSY);
   assign r_data_0 = r_data_m;
   assign r_data_1 = r_data_m;

   always_comb begin
      addr_m         = '0;
      w_data_m       = '0;
      w_sel_m        = '0;
      re_m           = 1'b0;
      we_m           = 1'b0;
      ready_0        = 1'b0;
      ready_1        = 1'b0;
      r_data_valid_0 = 1'b0;
      r_data_valid_1 = 1'b0;
      if (state == BUSY) begin
         if (grant) begin
            addr_m         = addr_1;
            w_data_m       = w_data_1;
            w_sel_m        = w_sel_1;
            re_m           = re_1;
            we_m           = we_1;
            ready_1        = ready_m & we_1;
            r_data_valid_1 = r_data_valid_m & re_1;
         end else begin
            addr_m         = addr_0;
            w_data_m       = w_data_0;
            w_sel_m        = w_sel_0;
            re_m           = re_0;
            we_m           = we_0;
            ready_0        = ready_m & we_0;
            r_data_valid_0 = r_data_valid_m & re_0;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vectors, expected completions are
// queued by the stimulus and popped by a negedge monitor.

module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] addr_0, w_data_0, addr_1, w_data_1;
   logic [3:0]  w_sel_0, w_sel_1;
   logic        re_0, we_0, re_1, we_1;
   logic [31:0] r_data_0, r_data_1;
   logic        ready_0, ready_1, r_data_valid_0, r_data_valid_1;
   logic [31:0] addr_m, w_data_m, r_data_m;
   logic [3:0]  w_sel_m;
   logic        re_m, we_m, ready_m, r_data_valid_m;
   logic        grant, busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        port;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   mem_bus_arbiter #(.AddrBusWidth(32), .BusWidth(32)) dut (
      .clk(clk), .rst(rst),
      .addr_0(addr_0), .w_data_0(w_data_0), .w_sel_0(w_sel_0),
      .re_0(re_0), .we_0(we_0), .r_data_0(r_data_0),
      .ready_0(ready_0), .r_data_valid_0(r_data_valid_0),
      .addr_1(addr_1), .w_data_1(w_data_1), .w_sel_1(w_sel_1),
      .re_1(re_1), .we_1(we_1), .r_data_1(r_data_1),
      .ready_1(ready_1), .r_data_valid_1(r_data_valid_1),
      .addr_m(addr_m), .w_data_m(w_data_m), .w_sel_m(w_sel_m),
      .re_m(re_m), .we_m(we_m), .r_data_m(r_data_m),
      .ready_m(ready_m), .r_data_valid_m(r_data_valid_m),
      .grant(grant), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: one fixed word at 0x08, otherwise a tag derived from the address.
   assign r_data_m = (addr_m == 32'h8) ? 32'h1122_3344 : (32'hA000_0000 | addr_m);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic port, input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.port = port; e.wr = wr; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   logic [1:0]  mon_rd, mon_wr;
   logic [31:0] mon_rdata [2];
   assign mon_rd = {r_data_valid_1, r_data_valid_0};
   assign mon_wr = {ready_1, ready_0};
   assign mon_rdata[0] = r_data_0;
   assign mon_rdata[1] = r_data_1;

   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            if (mon_rd[p] || mon_wr[p]) begin
               if (sb.size() == 0) begin
                  check("spurious_done", 32'(p), 32'hFFFF_FFFF);
               end else begin
                  mon_e = sb.pop_front();
                  check("done_port", 32'(p), 32'(mon_e.port));
                  check("done_kind", 32'(mon_wr[p]), 32'(mon_e.wr));
                  check("done_addr", addr_m, mon_e.addr);
                  if (mon_e.wr) check("done_wdata", w_data_m, mon_e.data);
                  else          check("done_rdata", mon_rdata[p], mon_e.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      addr_0 = '0; w_data_0 = '0; w_sel_0 = '0; re_0 = 1'b0; we_0 = 1'b0;
      addr_1 = '0; w_data_1 = '0; w_sel_1 = '0; re_1 = 1'b0; we_1 = 1'b0;
      ready_m = 1'b1; r_data_valid_m = 1'b1;

      // reset state
      #2;
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_re_m",  32'(re_m), 32'd0);
      check("rst_we_m",  32'(we_m), 32'd0);
      check("rst_addr_m", addr_m, 32'd0);
      step();
      rst = 1'b0;

      // lone read, zero wait
      re_0 = 1'b1; addr_0 = 32'h8;
      push(1'b0, 1'b0, 32'h8, 32'h1122_3344);
      sample();
      check("lone_latency_re_m", 32'(re_m), 32'd0);
      step();
      sample();
      check("lone_re_m",   32'(re_m), 32'd1);
      check("lone_addr_m", addr_m, 32'h8);
      check("lone_rvalid0", 32'(r_data_valid_0), 32'd1);
      check("lone_p1_out", {30'd0, ready_1, r_data_valid_1}, 32'd0);
      step();
      re_0 = 1'b0;
      sample();
      check("lone_idle", 32'(busy), 32'd0);

      // simultaneous continuous reads after reset: strict alternation from port 0
      rst = 1'b1;
      step();
      rst = 1'b0;
      re_0 = 1'b1; addr_0 = 32'h20;
      re_1 = 1'b1; addr_1 = 32'h30;
      for (int k = 0; k < 8; k++)
         push(k[0], 1'b0, k[0] ? 32'h30 : 32'h20, k[0] ? 32'hA000_0030 : 32'hA000_0020);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 8) re_0 = 1'b0;
         sample();
         check("rr_grant", 32'(grant), 32'((k - 1) % 2));
         check("rr_busy",  32'(busy), 32'd1);
      end
      step();
      re_1 = 1'b0;
      sample();
      check("rr_idle", 32'(busy), 32'd0);

      // port-1 write with three wait cycles, port 0 request arrives meanwhile
      ready_m = 1'b0; r_data_valid_m = 1'b0;
      we_1 = 1'b1; addr_1 = 32'h10; w_data_1 = 32'hDEAD_BEEF; w_sel_1 = 4'b1001;
      push(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 2) begin
            re_0 = 1'b1; addr_0 = 32'h40;
            push(1'b0, 1'b0, 32'h40, 32'hA000_0040);
         end
         if (k == 4) begin
            ready_m = 1'b1; r_data_valid_m = 1'b1;
         end
         sample();
         check("wr_addr_m",  addr_m, 32'h10);
         check("wr_wdata_m", w_data_m, 32'hDEAD_BEEF);
         check("wr_wsel_m",  32'(w_sel_m), 32'h9);
         check("wr_strobes", {30'd0, we_m, re_m}, 32'd2);
         check("wr_ready1",  32'(ready_1), 32'(k == 4));
      end
      step();
      we_1 = 1'b0;
      sample();
      check("wr_handover_grant", 32'(grant), 32'd0);
      check("wr_handover_addr",  addr_m, 32'h40);
      step();
      re_0 = 1'b0;
      sample();
      check("wr_idle", 32'(busy), 32'd0);

      // same-port back-to-back reads: one idle cycle between them
      re_0 = 1'b1; addr_0 = 32'h0;
      push(1'b0, 1'b0, 32'h0, 32'hA000_0000);
      push(1'b0, 1'b0, 32'h4, 32'hA000_0004);
      step();
      sample();
      check("b2b_busy_1", 32'(busy), 32'd1);
      step();
      addr_0 = 32'h4;
      sample();
      check("b2b_gap", 32'(busy), 32'd0);
      step();
      sample();
      check("b2b_busy_2", 32'(busy), 32'd1);
      check("b2b_addr_2", addr_m, 32'h4);
      step();
      re_0 = 1'b0;
      sample();
      check("b2b_idle", 32'(busy), 32'd0);

      // abort on port 0 with handover to a port-1 write
      ready_m = 1'b0; r_data_valid_m = 1'b0;
      re_0 = 1'b1; addr_0 = 32'h50;
      for (int k = 1; k <= 2; k++) begin
         step();
         sample();
         check("abort_wait_grant", 32'(grant), 32'd0);
         check("abort_wait_busy",  32'(busy), 32'd1);
      end
      step();
      re_0 = 1'b0;
      we_1 = 1'b1; addr_1 = 32'h60; w_data_1 = 32'h1234_5678; w_sel_1 = 4'hF;
      push(1'b1, 1'b1, 32'h60, 32'h1234_5678);
      sample();
      check("abort_still_busy", 32'(busy), 32'd1);
      step();
      ready_m = 1'b1; r_data_valid_m = 1'b1;
      sample();
      check("abort_handover_grant", 32'(grant), 32'd1);
      check("abort_handover_we_m",  32'(we_m), 32'd1);
      step();
      we_1 = 1'b0;
      sample();
      check("abort_idle", 32'(busy), 32'd0);

      // reset asserted between edges during a port-1 write
      ready_m = 1'b0; r_data_valid_m = 1'b0;
      we_1 = 1'b1; addr_1 = 32'h90; w_data_1 = 32'h5555_AAAA; w_sel_1 = 4'hF;
      step();
      sample();
      check("mid_pre_we_m",  32'(we_m), 32'd1);
      check("mid_pre_grant", 32'(grant), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_we_m",  32'(we_m), 32'd0);
      check("mid_rst_re_m",  32'(re_m), 32'd0);
      check("mid_rst_busy",  32'(busy), 32'd0);
      check("mid_rst_grant", 32'(grant), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      we_1 = 1'b0;
      ready_m = 1'b1; r_data_valid_m = 1'b1;
      re_0 = 1'b1; addr_0 = 32'h70;
      re_1 = 1'b1; addr_1 = 32'h80;
      push(1'b0, 1'b0, 32'h70, 32'hA000_0070);
      push(1'b1, 1'b0, 32'h80, 32'hA000_0080);
      step();
      sample();
      check("post_rst_first_grant", 32'(grant), 32'd0);
      step();
      re_0 = 1'b0;
      sample();
      check("post_rst_second_grant", 32'(grant), 32'd1);
      step();
      re_1 = 1'b0;
      sample();
      check("post_rst_idle", 32'(busy), 32'd0);

      step();
      step();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
